regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 32 x 32 register file (`register_file32`) among up to NREQ writeback sources, e.g. ALU, load unit and multiplier. Each source offers a write through a valid/ready handshake. A round-robin picker grants at most one write per cycle. The granted write is registered and driven onto the register file's `wen`/`wsel`/`in` port one cycle later. A pending-write tag is exported for hazard detection.

## Interface
- NREQ, 3: number of requesters, 2..8.
- DROP_R0, 0: when 1, accepted writes to address 0 are consumed but never reach the register file.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- hold  input  1  pipeline freeze: no grants while high.
- req_valid  input  NREQ  requester i has a write pending.
- req_ready  output  NREQ  one-hot grant; combinational from req_valid, hold and pointer.
- req_addr  input  NREQ*5  flattened; bits [5i+4:5i] belong to requester i.
- req_data  input  NREQ*32  flattened; bits [32i+31:32i] belong to requester i.
- rf_wen  output  1  to register file `wen`; registered.
- rf_wsel  output  5  to register file `wsel`; registered.
- rf_wdata  output  32  to register file `in`; registered.
- pend_valid  output  1  a write is in the output stage; equals rf_wen.
- pend_addr  output  5  address of that write; equals rf_wsel.

## Operation
- **Pointer.** `ptr`, width clog2(NREQ), names the highest-priority requester. The search order is ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
- **Grant.** req_ready[i] = 1 for the first i in search order with req_valid[i] = 1, and only when hold = 0. All other bits are 0.
  - At most one bit is set.
  - req_ready never depends on the requester's own ready.
- **Accept.** A handshake occurs when req_valid[i] & req_ready[i].
  - At that edge the output stage loads rf_wsel ← addr_i and rf_wdata ← data_i.
  - rf_wen ← 1, except rf_wen ← 0 when DROP_R0 = 1 and addr_i = 0.
  - The pointer moves to the requester after the winner: ptr ← i+1, wrapping NREQ-1 → 0.
- **No accept.** If there is no handshake, including any cycle with hold = 1:
  - rf_wen ← 0.
  - rf_wsel and rf_wdata keep their values.
  - ptr is unchanged.
- **Requester rules.** A requester must keep valid, addr and data stable until it is granted. The block samples them only in the grant cycle.
- **No write-port backpressure.** The register file accepts every cycle, so sustained throughput is one write per cycle.
- **Reset.** While reset = 0, and independent of clk:
  - ptr = 0, rf_wen = 0, rf_wsel = 0, rf_wdata = 0, so pend_valid = 0 and pend_addr = 0.
  - req_ready is forced to all zeros.
  - A write sitting in the output stage when reset asserts is discarded.

## Timing
- **Latency.** Handshake at edge N → rf_wen high during cycle N→N+1 → register file captures at edge N+1. The value is readable on out1/out0 after edge N+1.
- rf_wen is a single-cycle pulse per accepted write. Back-to-back accepts hold it high continuously.
- hold asserting in the same cycle as a request produces no grant. Deasserting hold makes grants available in the same cycle, combinationally.
- **All NREQ valid continuously.** Grants rotate ptr, ptr+1, … with no requester waiting more than NREQ-1 cycles.
- **Single requester valid.** It is granted every cycle regardless of ptr.
- **Duplicate addresses.** Two requesters targeting the same address in successive cycles produce two writes in grant order; the last one wins.
- pend_addr and pend_valid reflect only the output stage, not still-waiting requests.

## Structure
- Shared header/package constants:
  - REG_ADDR_W = 5 and REG_DATA_W = 32.
  - The `register_file32` port widths are derived from these.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: valid vector and ptr.
  - Outputs: one-hot grant and binary index.
  - Reusable for a future read-port arbiter.
- Top level holds ptr, the output stage and the DROP_R0 gate.

## Test plan
- **Reset mid-write.** Accept (addr 7, data 0xDEADBEEF), then assert reset before the next edge → rf_wen = 0 immediately; after release, ptr = 0 and reg7 is unchanged.
- **Full contention.** NREQ = 3, all valid continuously → grant sequence 0, 1, 2, 0, 1, 2; rf_wen high every cycle from the cycle after the first grant.
- **Rotation.** Only requesters 1 and 2 valid, ptr = 0 → grants 1, 2, 1, 2; requester 0 becomes valid later and is granted within 2 cycles.
- **Hold.** hold = 1 for 4 cycles with requester 0 valid → req_ready = 0, rf_wen = 0, ptr frozen; first grant in the cycle hold drops.
- **Drop r0.** DROP_R0 = 1 with a write to addr 0, data 0x1234 → handshake completes, rf_wen stays 0, ptr advances; with DROP_R0 = 0 the same write pulses rf_wen with wsel = 0.
- **End-to-end.** Requester 2 writes (addr 31, data 0xA5A5A5A5) → rf_wen/rf_wsel = 31 for one cycle; `register_file32` out1 with asel = 31 reads 0xA5A5A5A5 after edge N+1.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file geometry and small helpers for the write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // Round-robin successor of idx among n requesters.
  function automatic int next_ptr(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic          found;
  logic [PW-1:0] cand;
  int            j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      cand = PW'(j);
      if (!found && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ
// writeback sources; the granted write is registered onto wen/wsel/in.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int DROP_R0 = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hold,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NREQ*REG_DATA_W-1:0] req_data,
  output logic                       rf_wen,
  output logic [REG_ADDR_W-1:0]      rf_wsel,
  output logic [REG_DATA_W-1:0]      rf_wdata,
  output logic                       pend_valid,
  output logic [REG_ADDR_W-1:0]      pend_addr
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] pick_valid;
  logic [NREQ-1:0] grant;
  logic            accept;
  reg_addr_t       win_addr;
  reg_data_t       win_data;

  assign pick_valid = hold ? '0 : req_valid;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid (pick_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  // Reset forces ready low asynchronously so no source sees a phantom handshake.
  assign req_ready = reset ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign win_addr  = req_addr[int'(win_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign win_data  = req_data[int'(win_idx)*REG_DATA_W +: REG_DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      rf_wen   <= 1'b0;
      rf_wsel  <= '0;
      rf_wdata <= '0;
    end else if (accept) begin
      ptr      <= PW'(next_ptr(int'(win_idx), NREQ));
      rf_wsel  <= win_addr;
      rf_wdata <= win_data;
      // Writes to r0 are still handshaken so the source retires, just never issued.
      rf_wen   <= !((DROP_R0 != 0) && (win_addr == '0));
    end else begin
      rf_wen <= 1'b0;
    end
  end

  assign pend_valid = rf_wen;
  assign pend_addr  = rf_wsel;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus multi-cycle sequences.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready, req_ready_d;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        rf_wen, rf_wen_d;
  logic [4:0]  rf_wsel, rf_wsel_d;
  logic [31:0] rf_wdata, rf_wdata_d;
  logic        pend_valid, pend_valid_d;
  logic [4:0]  pend_addr, pend_addr_d;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf_model [32];

  regfile_write_arbiter #(.NREQ(3), .DROP_R0(0)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_addr(pend_addr)
  );

  regfile_write_arbiter #(.NREQ(3), .DROP_R0(1)) dut_d (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready_d),
    .req_addr(req_addr), .req_data(req_data),
    .rf_wen(rf_wen_d), .rf_wsel(rf_wsel_d), .rf_wdata(rf_wdata_d),
    .pend_valid(pend_valid_d), .pend_addr(pend_addr_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model standing in for register_file32.
  always @(posedge clk) begin
    if (rf_wen) rf_model[rf_wsel] <= rf_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] valid;
    logic       hold;
    logic [2:0] ready;
    logic [1:0] ptr;
  } vec_t;

  vec_t        vecs [22];
  logic [4:0]  base_addr [3];
  logic [4:0]  exp_wsel;
  logic [31:0] exp_wdata;
  int          widx;

  initial begin
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    base_addr[0] = 5'd5;
    base_addr[1] = 5'd9;
    base_addr[2] = 5'd17;

    // Full contention, rotation, late requester 0, hold, single requester, mixed pairs.
    vecs[0]  = '{3'b111, 1'b0, 3'b001, 2'd1};
    vecs[1]  = '{3'b111, 1'b0, 3'b010, 2'd2};
    vecs[2]  = '{3'b111, 1'b0, 3'b100, 2'd0};
    vecs[3]  = '{3'b111, 1'b0, 3'b001, 2'd1};
    vecs[4]  = '{3'b111, 1'b0, 3'b010, 2'd2};
    vecs[5]  = '{3'b111, 1'b0, 3'b100, 2'd0};
    vecs[6]  = '{3'b110, 1'b0, 3'b010, 2'd2};
    vecs[7]  = '{3'b110, 1'b0, 3'b100, 2'd0};
    vecs[8]  = '{3'b110, 1'b0, 3'b010, 2'd2};
    vecs[9]  = '{3'b111, 1'b0, 3'b100, 2'd0};
    vecs[10] = '{3'b111, 1'b0, 3'b001, 2'd1};
    vecs[11] = '{3'b001, 1'b1, 3'b000, 2'd1};
    vecs[12] = '{3'b001, 1'b1, 3'b000, 2'd1};
    vecs[13] = '{3'b001, 1'b1, 3'b000, 2'd1};
    vecs[14] = '{3'b001, 1'b1, 3'b000, 2'd1};
    vecs[15] = '{3'b001, 1'b0, 3'b001, 2'd1};
    vecs[16] = '{3'b000, 1'b0, 3'b000, 2'd1};
    vecs[17] = '{3'b100, 1'b0, 3'b100, 2'd0};
    vecs[18] = '{3'b100, 1'b0, 3'b100, 2'd0};
    vecs[19] = '{3'b011, 1'b0, 3'b001, 2'd1};
    vecs[20] = '{3'b011, 1'b0, 3'b010, 2'd2};
    vecs[21] = '{3'b101, 1'b0, 3'b100, 2'd0};

    reset     = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    #12;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_wen", 32'(rf_wen), 32'h0);
    chk("reset_wsel", 32'(rf_wsel), 32'h0);
    chk("reset_wdata", rf_wdata, 32'h0);
    chk("reset_pend", {26'h0, pend_valid, pend_addr}, 32'h0);
    chk("reset_ptr", 32'(dut.ptr), 32'h0);

    tick();
    req_valid = 3'b000;
    reset     = 1'b1;

    exp_wsel  = '0;
    exp_wdata = '0;
    for (int k = 0; k < 22; k++) begin
      req_valid = vecs[k].valid;
      hold      = vecs[k].hold;
      for (int i = 0; i < 3; i++)
        set_req(i, base_addr[i], 32'hC000_0000 | (k << 4) | i);
      #1;
      chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].ready));
      widx = -1;
      for (int i = 0; i < 3; i++) if (vecs[k].ready[i]) widx = i;
      if (widx >= 0) begin
        exp_wsel  = base_addr[widx];
        exp_wdata = 32'hC000_0000 | (k << 4) | widx;
      end
      tick();
      chk($sformatf("v%0d_wen", k), 32'(rf_wen), 32'(widx >= 0));
      chk($sformatf("v%0d_wsel", k), 32'(rf_wsel), 32'(exp_wsel));
      chk($sformatf("v%0d_wdata", k), rf_wdata, exp_wdata);
      chk($sformatf("v%0d_pend", k), {26'h0, pend_valid, pend_addr}, {26'h0, (widx >= 0), exp_wsel});
      chk($sformatf("v%0d_ptr", k), 32'(dut.ptr), 32'(vecs[k].ptr));
    end
    hold = 1'b0;

    // Write to r0: DROP_R0=1 instance consumes it silently, default instance issues it.
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h0000_1234);
    #1;
    chk("drop_ready", 32'(req_ready_d), 32'h1);
    tick();
    chk("drop_wen", 32'(rf_wen_d), 32'h0);
    chk("drop_ptr", 32'(dut_d.ptr), 32'h1);
    chk("nodrop_wen", 32'(rf_wen), 32'h1);
    chk("nodrop_wsel", 32'(rf_wsel), 32'h0);
    chk("nodrop_wdata", rf_wdata, 32'h0000_1234);
    req_valid = 3'b000;
    tick();
    chk("nodrop_pulse", 32'(rf_wen), 32'h0);

    // End-to-end through the register file model (ptr=1, only requester 2 valid).
    req_valid = 3'b100;
    set_req(2, 5'd31, 32'hA5A5_A5A5);
    tick();
    chk("e2e_wen", 32'(rf_wen), 32'h1);
    chk("e2e_wsel", 32'(pend_addr), 32'd31);
    req_valid = 3'b000;
    tick();
    chk("e2e_wen_off", 32'(rf_wen), 32'h0);
    chk("e2e_read", rf_model[31], 32'hA5A5_A5A5);

    // Same address from two requesters in successive cycles: later grant wins.
    set_req(0, 5'd3, 32'h0000_0111);
    set_req(1, 5'd3, 32'h0000_0222);
    req_valid = 3'b011;
    #1;
    chk("dup_first", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b010;
    #1;
    chk("dup_second", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    tick();
    chk("dup_final", rf_model[3], 32'h0000_0222);

    // Reset arriving while a write sits in the output stage.
    req_valid = 3'b001;
    set_req(0, 5'd7, 32'hDEAD_BEEF);
    tick();
    chk("rmw_wen", 32'(rf_wen), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("rmw_wen_clr", 32'(rf_wen), 32'h0);
    chk("rmw_wsel_clr", 32'(rf_wsel), 32'h0);
    chk("rmw_wdata_clr", rf_wdata, 32'h0);
    chk("rmw_ready", 32'(req_ready), 32'h0);
    tick();
    chk("rmw_reg7", rf_model[7], 32'h0);
    req_valid = 3'b101;
    reset     = 1'b1;
    #1;
    chk("rmw_ptr", 32'(dut.ptr), 32'h0);
    chk("rmw_ready_after", 32'(req_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
